// File: rtl/uart_pkg.sv
// Shared types for the UART transmit feeder: FSM states and the FIFO entry layout.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [1:0]  nbytes_m1;
    logic [31:0] data;
  } tx_entry_t;

  localparam int ENTRY_W = $bits(tx_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and an occupancy counter.
module sync_fifo #(
  parameter int WIDTH      = 34,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Guard against overflow/underflow even if the caller does not.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues 1-4 byte words and hands them to the UART serializer one byte per tx_start pulse.
// Handshake: a word transfers on a posedge where in_valid && in_ready; in_ready never depends on in_valid.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic [1:0]            in_nbytes,
  output logic [7:0]            sdata,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  idle
);

  feeder_state_t state;
  tx_entry_t     wr_entry;
  tx_entry_t     head;
  logic [23:0]   word_r;
  logic [1:0]    rem_r;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign wr_entry = '{nbytes_m1: in_nbytes, data: in_data};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && !fifo_empty && !tx_busy;

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte 0 goes straight to sdata on pop, so word_r only keeps the upper three bytes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      word_r   <= '0;
      rem_r    <= '0;
      sdata    <= '0;
      tx_start <= 1'b0;
      idle     <= 1'b1;
    end else begin
      tx_start <= 1'b0;
      idle     <= fifo_empty && (state == S_IDLE) && !tx_busy;
      case (state)
        S_IDLE: begin
          if (pop) begin
            word_r   <= head.data[31:8];
            rem_r    <= head.nbytes_m1;
            sdata    <= head.data[7:0];
            tx_start <= 1'b1;
            state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tx_busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (rem_r != 2'd0) begin
              word_r   <= {8'h00, word_r[23:8]};
              rem_r    <= rem_r - 2'd1;
              sdata    <= word_r[7:0];
              tx_start <= 1'b1;
              state    <= S_WAIT_HI;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench: feeder driving a simple 8-clock-per-bit serializer, with a serial monitor scoreboard.
module tb_uart_tx_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_nbytes = '0;
  logic [7:0]  sdata;
  logic        tx_start;
  logic        tx_busy;
  logic [4:0]  fifo_count;
  logic        idle;
  logic        txd;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int viol = 0;
  logic start_d1 = 1'b0;
  logic mon_act = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_nbytes  (in_nbytes),
    .sdata      (sdata),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  // Serializer: CLK_PER_HALF_BIT=4, i.e. 8 clocks per bit, 10-bit frame.
  logic [9:0] tx_frame;
  logic [3:0] tx_bit;
  logic [2:0] tx_ctr;
  assign txd = tx_busy ? tx_frame[tx_bit] : 1'b1;

  always_ff @(posedge clk) begin
    if (!tx_rstn) begin
      tx_busy  <= 1'b0;
      tx_frame <= '1;
      tx_bit   <= '0;
      tx_ctr   <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        tx_frame <= {1'b1, sdata, 1'b0};
        tx_bit   <= '0;
        tx_ctr   <= '0;
      end
    end else if (tx_ctr == 3'd7) begin
      tx_ctr <= '0;
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
      else tx_bit <= tx_bit + 4'd1;
    end else begin
      tx_ctr <= tx_ctr + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) pulses++;
    if (tx_start && (tx_busy || start_d1)) viol++;
    start_d1 <= tx_start;
  end

  // Serial monitor: start bit seen at offset 0, data bits sampled mid-bit.
  initial begin
    int ctr;
    logic [7:0] sh;
    ctr = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (!mon_act) begin
        if (txd == 1'b0) begin
          mon_act = 1'b1;
          ctr = 0;
        end
      end else begin
        ctr++;
        if ((ctr % 8 == 4) && (ctr < 76)) sh[(ctr / 8) - 1] = txd;
        if (ctr == 76) begin
          chk("rx_stop", txd, 1);
          chk("rx_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("rx_byte", sh, exp_q.pop_front());
          mon_act = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic [1:0] nb, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_nbytes = nb;
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("push_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] nb);
    int w;
    push_word(d, nb, w);
    for (int i = 0; i <= int'(nb); i++) exp_q.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_pulse(input string tag, output logic b1, output logic b2);
    logic p1, p2;
    int n;
    p1 = 1'b0;
    p2 = 1'b0;
    n = 0;
    b1 = 1'b0;
    b2 = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      if (tx_start) break;
      p2 = p1;
      p1 = tx_busy;
      n++;
    end
    chk(tag, tx_start, 1);
    b1 = p1;
    b2 = p2;
  endtask

  task automatic wait_busy_fall();
    logic prev;
    int n;
    prev = tx_busy;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (prev && !tx_busy) break;
      prev = tx_busy;
      n++;
    end
    chk("busy_fall_seen", n < 2000, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_act || !idle || tx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    int w, p0, acc;
    logic b1, b2;
    logic [7:0] k;

    repeat (3) @(negedge clk);
    tx_rstn = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_sdata", sdata, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);

    // 1: single byte, latency N+2
    p0 = pulses;
    push_word(32'h0000_00A5, 2'd0, w);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    chk("t1_no_pulse_n1", tx_start, 0);
    @(negedge clk);
    chk("t1_pulse_n2", tx_start, 1);
    chk("t1_sdata", sdata, 8'hA5);
    @(negedge clk);
    chk("t1_pulse_one_cycle", tx_start, 0);
    chk("t1_sdata_hold", sdata, 8'hA5);
    drain("t1");
    chk("t1_pulse_count", pulses - p0, 1);

    // 2: four-byte word, LSB first, each follow-on pulse one cycle after busy falls
    p0 = pulses;
    push_exp(32'h4433_2211, 2'd3);
    wait_pulse("t2_pulse0", b1, b2);
    chk("t2_sdata0", sdata, 8'h11);
    wait_pulse("t2_pulse1", b1, b2);
    chk("t2_sdata1", sdata, 8'h22);
    chk("t2_gap1", {b2, b1}, 2'b10);
    wait_pulse("t2_pulse2", b1, b2);
    chk("t2_sdata2", sdata, 8'h33);
    chk("t2_gap2", {b2, b1}, 2'b10);
    wait_pulse("t2_pulse3", b1, b2);
    chk("t2_sdata3", sdata, 8'h44);
    chk("t2_gap3", {b2, b1}, 2'b10);
    drain("t2");
    chk("t2_pulse_count", pulses - p0, 4);

    // 3: fill to full while a byte is on the wire, 17th push held
    push_exp(32'hEE, 2'd0);
    wait_pulse("t3_first", b1, b2);
    for (int i = 0; i < 16; i++) push_exp(i, 2'd0);
    @(negedge clk);
    chk("t3_count_full", fifo_count, 16);
    chk("t3_ready_full", in_ready, 0);
    push_word(32'h10, 2'd0, w);
    exp_q.push_back(8'h10);
    chk("t3_push_held", w > 0, 1);
    @(negedge clk);
    chk("t3_count_refill", fifo_count, 16);
    drain("t3");

    // 4: in_valid held high for 100 cycles
    p0 = pulses;
    acc = 0;
    k = 8'h40;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = {24'h0, k};
      in_nbytes = 2'd0;
      if (in_ready) begin
        exp_q.push_back(k);
        k = k + 8'd1;
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("t4");
    chk("t4_sent_eq_accepted", pulses - p0, acc);
    chk("t4_accepted_min", acc >= 17, 1);

    // 5: reset during byte 0 of a 4-byte word
    push_word(32'hDDCC_BBAA, 2'd3, w);
    exp_q.push_back(8'hAA);
    wait_pulse("t5_first", b1, b2);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("t5_tx_start", tx_start, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_in_ready", in_ready, 1);
    p0 = pulses;
    repeat (300) @(negedge clk);
    chk("t5_no_pulses", pulses - p0, 0);
    drain("t5");
    push_exp(32'h5A, 2'd0);
    drain("t5_after");

    // 6a: push and pop in the same cycle at count=5
    push_exp(32'h77, 2'd0);
    wait_pulse("t6a_first", b1, b2);
    for (int i = 0; i < 5; i++) push_exp(32'h80 + i, 2'd0);
    wait_busy_fall();
    @(negedge clk);
    chk("t6a_count_before", fifo_count, 5);
    in_valid = 1'b1;
    in_data = 32'h85;
    in_nbytes = 2'd0;
    exp_q.push_back(8'h85);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6a_count_same", fifo_count, 5);
    chk("t6a_ready", in_ready, 1);
    chk("t6a_popped", tx_start, 1);
    drain("t6a");

    // 6b: at count=16 the same-cycle push is refused
    push_exp(32'h66, 2'd0);
    wait_pulse("t6b_first", b1, b2);
    for (int i = 0; i < 16; i++) push_exp(32'hC0 + i, 2'd0);
    wait_busy_fall();
    @(negedge clk);
    chk("t6b_ready_full", in_ready, 0);
    in_valid = 1'b1;
    in_data = 32'h99;
    in_nbytes = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6b_count_popped", fifo_count, 15);
    chk("t6b_ready_after", in_ready, 1);
    chk("t6b_popped", tx_start, 1);
    drain("t6b");

    chk("no_start_while_busy", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
